ss_frame_deser: RTL and testbench
=================================

SS_FRAME_DESER -- requirements
Module: ss_frame_deser

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port en, input, 1, bit-sample enable; when low, all state holds.
REQ-004 SHALL have port ser_in, input, 1, serial bit stream from the upstream serial shift register output.
REQ-005 SHALL have port lsb_first, input, 1: 1 = first data bit lands in data_out[0]; 0 = first data bit lands in data_out[7].
REQ-006 SHALL have port ack, input, 1, consumer acknowledge; clears valid.
REQ-007 SHALL have port clr_err, input, 1, clears the sticky error flags.
REQ-008 SHALL have port data_out, output, 8, last good received byte.
REQ-009 SHALL have port valid, output, 1, data_out holds an unacknowledged byte.
REQ-010 SHALL have port parity_err, output, 1, parity status of the byte in data_out.
REQ-011 SHALL have port frame_err, output, 1, sticky flag for a bad stop bit.
REQ-012 SHALL have port overrun, output, 1, sticky flag for a byte lost to an unacknowledged valid.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 Frame format SHALL be: start bit (0), 8 data bits, even-parity bit, stop bit (1); one bit is consumed per clk edge with en=1.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: en=1 and ser_in=0 SHALL go to DATA, clear the bit counter, and latch lsb_first for the whole frame; ser_in=1 stays IDLE.
REQ-017 DATA: each enabled edge SHALL shift ser_in into an 8-bit shift register and increment a 3-bit counter.
REQ-018 The shift direction in DATA SHALL be right-shift (insert at bit 7) when latched lsb_first=1, and left-shift (insert at bit 0) otherwise.
REQ-019 DATA SHALL go to PARITY after the 8th data bit (counter wrap 7->0).
REQ-020 PARITY SHALL capture ser_in as the parity bit and go to STOP.
REQ-021 STOP with ser_in=1 SHALL load data_out from the shift register and set valid=1.
REQ-022 STOP with ser_in=1 SHALL set parity_err=1 iff the XOR of the 8 data bits and the parity bit is 1.
REQ-023 STOP with ser_in=0 SHALL set frame_err=1, discard the byte, and leave data_out, valid and parity_err unchanged.
REQ-024 STOP SHALL always return to IDLE; no back-to-back start is taken in the STOP cycle.
REQ-025 Latency SHALL be: start bit sampled at edge N, and valid/data_out visible after edge N+10.
REQ-026 ack=1 SHALL clear valid on the next edge, independent of en.
REQ-027 A good-frame load in the same edge as ack=1 SHALL leave valid=1 with the new data and no overrun.
REQ-028 A good-frame load while valid=1 and ack=0 SHALL overwrite data_out and set overrun=1.
REQ-029 clr_err=1 SHALL clear frame_err and overrun on the next edge.
REQ-030 A set event in the same edge as clr_err=1 SHALL win, leaving the flag at 1.
REQ-031 en=0 mid-frame SHALL freeze the FSM, counter and shift register; ack and clr_err still act.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, shift register=0x00, data_out=0x00, and valid, parity_err, frame_err, overrun, busy = 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no valid pulse.
REQ-034 After reset release, the first ser_in=0 with en=1 SHALL be treated as a start bit.

Verification
REQ-035 Bench SHALL cover LSB-first good frame: lsb_first=1, bits 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop) -> data_out=0xA5, valid=1 ten edges after start, parity_err=0.
REQ-036 Bench SHALL cover MSB-first bad parity: lsb_first=0, start, 0x3C MSB first, parity 1, stop -> data_out=0x3C, parity_err=1, valid=1.
REQ-037 Bench SHALL cover bad stop bit: good frame then frame with stop=0 -> frame_err=1, data_out and valid unchanged; clr_err -> frame_err=0.
REQ-038 Bench SHALL cover overrun and ack race: two good frames 0x11, 0x22 with no ack -> data_out=0x22, overrun=1; repeat with ack on the load edge -> overrun=0, valid=1.
REQ-039 Bench SHALL cover en gaps and reset: en toggled 0/1 inside a frame -> same result as contiguous; rst_n pulsed after the 4th data bit -> all outputs 0, busy=0, no valid.

Source files
------------

// File: rtl/ss_frame_deser.sv
// Serial frame deserializer: start, 8 data bits, even parity, stop.
// Delivers the last good byte with valid/parity status and sticky error flags.
//
// state  | meaning
// IDLE   | waiting for a start bit (ser_in=0)
// DATA   | shifting in the 8 data bits
// PARITY | capturing the parity bit
// STOP   | checking the stop bit, loading data_out on success
module ss_frame_deser (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       ser_in,
   input  logic       lsb_first,
   input  logic       ack,
   input  logic       clr_err,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       lsb_lat;
   logic       par_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         lsb_lat    <= 1'b0;
         par_bit    <= 1'b0;
         data_out   <= 8'h00;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Clears come first so that a same-edge set below takes priority.
         if (ack) begin
            valid <= 1'b0;
         end
         if (clr_err) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
         end

         if (en) begin
            case (state)
               IDLE: begin
                  if (!ser_in) begin
                     state   <= DATA;
                     bit_cnt <= 3'd0;
                     lsb_lat <= lsb_first;
                     busy    <= 1'b1;
                  end
               end
               DATA: begin
                  if (lsb_lat) begin
                     shreg <= {ser_in, shreg[7:1]};
                  end else begin
                     shreg <= {shreg[6:0], ser_in};
                  end
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  par_bit <= ser_in;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (ser_in) begin
                     data_out   <= shreg;
                     valid      <= 1'b1;
                     parity_err <= (^shreg) ^ par_bit;
                     if (valid && !ack) begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ss_frame_deser.sv
// Self-checking bench for ss_frame_deser: directed frames plus randomized frames
// compared every clock against a bit-queue reference model.
module tb_ss_frame_deser;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       ser_in;
   logic       lsb_first;
   logic       ack;
   logic       clr_err;
   logic [7:0] data_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   bit       m_in_frame;
   bit       m_lsb;
   int       m_bits[$];
   bit [7:0] m_data;
   bit       m_valid;
   bit       m_perr;
   bit       m_ferr;
   bit       m_ovr;

   ss_frame_deser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .ser_in     (ser_in),
      .lsb_first  (lsb_first),
      .ack        (ack),
      .clr_err    (clr_err),
      .data_out   (data_out),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic model_reset();
      m_in_frame = 0;
      m_lsb      = 0;
      m_bits.delete();
      m_data     = 8'h00;
      m_valid    = 0;
      m_perr     = 0;
      m_ferr     = 0;
      m_ovr      = 0;
   endtask

   // Frame-level model: collect bits after a start bit, judge the frame once
   // data, parity and stop (10 bits) have arrived.
   task automatic model_edge();
      bit old_valid;
      int val;
      int ones;
      old_valid = m_valid;
      if (ack) m_valid = 0;
      if (clr_err) begin
         m_ferr = 0;
         m_ovr  = 0;
      end
      if (en) begin
         if (!m_in_frame) begin
            if (ser_in == 1'b0) begin
               m_in_frame = 1;
               m_lsb      = lsb_first;
               m_bits.delete();
            end
         end else begin
            m_bits.push_back(int'(ser_in));
            if (m_bits.size() == 10) begin
               m_in_frame = 0;
               if (m_bits[9] == 1) begin
                  val  = 0;
                  ones = 0;
                  for (int i = 0; i < 8; i++) begin
                     if (m_bits[i] == 1) begin
                        val  += m_lsb ? (1 << i) : (1 << (7 - i));
                        ones += 1;
                     end
                  end
                  ones += m_bits[8];
                  if (old_valid && !ack) m_ovr = 1;
                  m_data  = val[7:0];
                  m_valid = 1;
                  m_perr  = (ones % 2) == 1;
               end else begin
                  m_ferr = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk("data_out",   {24'h0, data_out}, {24'h0, m_data});
      chk("valid",      {31'h0, valid},      {31'h0, m_valid});
      chk("parity_err", {31'h0, parity_err}, {31'h0, m_perr});
      chk("frame_err",  {31'h0, frame_err},  {31'h0, m_ferr});
      chk("overrun",    {31'h0, overrun},    {31'h0, m_ovr});
      chk("busy",       {31'h0, busy},       {31'h0, m_in_frame});
   endtask

   task automatic step(input logic b, input logic e, input logic a, input logic c);
      ser_in  = b;
      en      = e;
      ack     = a;
      clr_err = c;
      @(posedge clk);
      #1;
      model_edge();
      check_all();
      ack     = 1'b0;
      clr_err = 1'b0;
      en      = 1'b1;
      ser_in  = 1'b1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_all();
      chk("rst_data",  {24'h0, data_out}, 32'h0);
      chk("rst_busy",  {31'h0, busy},     32'h0);
      chk("rst_valid", {31'h0, valid},    32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Sends one frame. gaps inserts random en=0 cycles, rnd_ctl adds random
   // ack/clr_err, ack_last asserts ack on the stop (load) edge.
   task automatic send_frame(input logic [7:0] d, input logic lsb, input logic par_flip,
                             input logic stop_b, input logic gaps, input logic rnd_ctl,
                             input logic ack_last);
      logic [10:0] bits;
      logic        a;
      logic        c;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = lsb ? d[i] : d[7 - i];
      bits[9]  = (^d) ^ par_flip;
      bits[10] = stop_b;
      lsb_first = lsb;
      for (int i = 0; i < 11; i++) begin
         while (gaps && ($urandom_range(0, 2) == 0))
            step(1'($urandom), 1'b0, rnd_ctl && ($urandom_range(0, 7) == 0),
                 rnd_ctl && ($urandom_range(0, 7) == 0));
         a = (i == 10) ? ack_last : (rnd_ctl && ($urandom_range(0, 7) == 0));
         c = rnd_ctl && ($urandom_range(0, 7) == 0);
         step(bits[i], 1'b1, a, c);
         if (i == 0) lsb_first = 1'($urandom);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      ser_in    = 1'b1;
      lsb_first = 1'b0;
      ack       = 1'b0;
      clr_err   = 1'b0;
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(1, 1, 0, 0);

      // LSB-first 0xA5, good parity; valid only after the 10th edge past start
      lsb_first = 1'b1;
      step(0, 1, 0, 0);
      for (int i = 0; i < 9; i++) step((i < 8) ? ((8'hA5 >> i) & 1) : 0, 1, 0, 0);
      chk("a5_valid_early", {31'h0, valid}, 32'h0);
      step(1, 1, 0, 0);
      chk("a5_data",  {24'h0, data_out}, 32'hA5);
      chk("a5_valid", {31'h0, valid}, 32'h1);
      chk("a5_perr",  {31'h0, parity_err}, 32'h0);
      step(1, 1, 1, 0);

      // MSB-first 0x3C with wrong parity
      send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("3c_data",  {24'h0, data_out}, 32'h3C);
      chk("3c_perr",  {31'h0, parity_err}, 32'h1);
      chk("3c_valid", {31'h0, valid}, 32'h1);
      step(1, 1, 1, 0);

      // good frame then bad stop bit
      send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ferr_set",   {31'h0, frame_err}, 32'h1);
      chk("ferr_data",  {24'h0, data_out}, 32'h96);
      chk("ferr_valid", {31'h0, valid}, 32'h1);
      step(1, 1, 0, 1);
      chk("ferr_clr", {31'h0, frame_err}, 32'h0);
      step(1, 1, 1, 0);

      // overrun, then ack racing the load
      send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovr_data", {24'h0, data_out}, 32'h22);
      chk("ovr_set",  {31'h0, overrun}, 32'h1);
      step(1, 1, 1, 1);
      chk("ovr_clr", {31'h0, overrun}, 32'h0);
      send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("race_ovr",   {31'h0, overrun}, 32'h0);
      chk("race_valid", {31'h0, valid}, 32'h1);
      chk("race_data",  {24'h0, data_out}, 32'h22);
      step(1, 1, 1, 0);

      // en gaps inside a frame
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("gap_data",  {24'h0, data_out}, 32'h5A);
      chk("gap_valid", {31'h0, valid}, 32'h1);
      chk("gap_perr",  {31'h0, parity_err}, 32'h0);
      step(1, 1, 1, 0);

      // reset after the 4th data bit abandons the frame
      lsb_first = 1'b1;
      step(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(1'(i), 1, 0, 0);
      chk("mid_busy", {31'h0, busy}, 32'h1);
      pulse_reset();
      for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
      chk("post_rst_valid", {31'h0, valid}, 32'h0);
      send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_data", {24'h0, data_out}, 32'hC3);

      // randomized frames with gaps, idle time, ack/clr_err and bad stops
      for (int f = 0; f < 40; f++) begin
         send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) != 0), 1'($urandom), 1'b1, 1'($urandom));
         repeat ($urandom_range(0, 3))
            step(1, 1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
